// File: rtl/jpc_pcgen.sv
// Program-counter generator: issues sequential PCs to ifetch over a valid/ready
// handshake, applies epoch-tagged redirects, supports halt and traps misaligned targets.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif
`ifndef JPC_NULL_ADDRESS
`define JPC_NULL_ADDRESS 0
`endif

module jpc_pcgen #(
    parameter int ADDR_WIDTH  = `JPC_ADDRESS_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(`JPC_NULL_ADDRESS),
    parameter int PC_STEP     = 4,
    parameter int EPOCH_WIDTH = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc_O,
    output logic                   pc_valid_O,
    input  logic                   pc_ready_I,
    output logic [EPOCH_WIDTH-1:0] pc_epoch_O,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_I,
    input  logic                   redirect_valid_I,
    input  logic                   halt_I,
    output logic                   halted_O,
    output logic                   err_O,
    output logic [CNT_WIDTH-1:0]   issued_cnt_O
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(PC_STEP - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

    state_t                 state_r, state_s;
    logic                   boot_done_r, boot_done_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_s;
    logic                   valid_r, valid_s;
    logic [EPOCH_WIDTH-1:0] epoch_r, epoch_s;
    logic                   halted_r, halted_s;
    logic                   err_r, err_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic                   accept_s;
    logic                   misalign_s;
    logic                   redirect_ok_s;

    assign accept_s      = valid_r & pc_ready_I;
    assign misalign_s    = redirect_valid_I & ((redirect_pc_I & ALIGN_MASK) != '0);
    assign redirect_ok_s = redirect_valid_I & ~misalign_s;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= BOOT;
            boot_done_r <= 1'b0;
            pc_r        <= RESET_PC;
            valid_r     <= 1'b0;
            epoch_r     <= '0;
            halted_r    <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_s;
            boot_done_r <= boot_done_s;
            pc_r        <= pc_s;
            valid_r     <= valid_s;
            epoch_r     <= epoch_s;
            halted_r    <= halted_s;
            err_r       <= err_s;
            cnt_r       <= cnt_s;
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_s     = state_r;
        boot_done_s = boot_done_r;
        pc_s        = pc_r;
        valid_s     = valid_r;
        epoch_s     = epoch_r;
        halted_s    = halted_r;
        err_s       = err_r;
        cnt_s       = cnt_r;

        // A handshake always counts, even when a trap is taken in the same cycle.
        if (accept_s) begin
            cnt_s = cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_s = cnt_r;
        end

        case (state_r)
            BOOT: begin
                valid_s = 1'b0;
                if (misalign_s) begin
                    state_s = ERROR;
                    err_s   = 1'b1;
                end else begin
                    if (redirect_ok_s) begin
                        pc_s    = redirect_pc_I;
                        epoch_s = epoch_r + EPOCH_WIDTH'(1);
                    end else begin
                        pc_s = pc_r;
                    end
                    if (!boot_done_r) begin
                        boot_done_s = 1'b1;
                    end else if (halt_I) begin
                        state_s  = HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s = RUN;
                        valid_s = 1'b1;
                    end
                end
            end
            RUN: begin
                if (misalign_s) begin
                    state_s  = ERROR;
                    valid_s  = 1'b0;
                    halted_s = 1'b0;
                    err_s    = 1'b1;
                    if (accept_s) begin
                        pc_s = pc_r + STEP;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    if (redirect_ok_s) begin
                        pc_s    = redirect_pc_I;
                        epoch_s = epoch_r + EPOCH_WIDTH'(1);
                    end else if (accept_s) begin
                        pc_s = pc_r + STEP;
                    end else begin
                        pc_s = pc_r;
                    end
                    // Halt only once no offer is left hanging.
                    if (halt_I && (!valid_r || accept_s)) begin
                        state_s  = HALT;
                        valid_s  = 1'b0;
                        halted_s = 1'b1;
                    end else begin
                        valid_s = 1'b1;
                    end
                end
            end
            HALT: begin
                valid_s = 1'b0;
                if (misalign_s) begin
                    state_s  = ERROR;
                    halted_s = 1'b0;
                    err_s    = 1'b1;
                end else begin
                    if (redirect_ok_s) begin
                        pc_s    = redirect_pc_I;
                        epoch_s = epoch_r + EPOCH_WIDTH'(1);
                    end else begin
                        pc_s = pc_r;
                    end
                    if (!halt_I) begin
                        state_s  = RUN;
                        valid_s  = 1'b1;
                        halted_s = 1'b0;
                    end else begin
                        halted_s = 1'b1;
                    end
                end
            end
            ERROR: begin
                valid_s  = 1'b0;
                halted_s = 1'b0;
                err_s    = 1'b1;
            end
            default: begin
                state_s  = ERROR;
                valid_s  = 1'b0;
                halted_s = 1'b0;
                err_s    = 1'b1;
            end
        endcase
    end

    assign pc_O         = pc_r;
    assign pc_valid_O   = valid_r;
    assign pc_epoch_O   = epoch_r;
    assign halted_O     = halted_r;
    assign err_O        = err_r;
    assign issued_cnt_O = cnt_r;

endmodule

// File: tb/tb_jpc_pcgen.sv
// Directed bench for jpc_pcgen; accepted PCs are checked against a scoreboard
// of expected {epoch, pc} pairs pushed by the stimulus.
`timescale 1ns/1ps

module tb_jpc_pcgen;

    logic        clk;
    logic        rst;
    logic [31:0] pc_O;
    logic        pc_valid_O;
    logic        pc_ready_I;
    logic [1:0]  pc_epoch_O;
    logic [31:0] redirect_pc_I;
    logic        redirect_valid_I;
    logic        halt_I;
    logic        halted_O;
    logic        err_O;
    logic [31:0] issued_cnt_O;

    typedef struct packed {
        logic [1:0]  epoch;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    jpc_pcgen #(
        .ADDR_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .EPOCH_WIDTH(2), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .pc_O(pc_O), .pc_valid_O(pc_valid_O), .pc_ready_I(pc_ready_I),
        .pc_epoch_O(pc_epoch_O),
        .redirect_pc_I(redirect_pc_I), .redirect_valid_I(redirect_valid_I),
        .halt_I(halt_I), .halted_O(halted_O), .err_O(err_O),
        .issued_cnt_O(issued_cnt_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] epoch, input logic [31:0] pc);
        exp_t e;
        e.epoch = epoch;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // One clock: score any handshake about to happen, then sample #1 after the edge.
    task automatic cycle();
        exp_t e;
        if (pc_valid_O && pc_ready_I) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 64'(pc_O), 64'(e.pc));
                check("sb_epoch", 64'(pc_epoch_O), 64'(e.epoch));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_pc_I    = target;
        redirect_valid_I = 1'b1;
        cycle();
        redirect_valid_I = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; pc_ready_I = 1'b0; redirect_pc_I = 32'h0;
        redirect_valid_I = 1'b0; halt_I = 1'b0;
        cycle(); cycle();
        check("rst_pc", 64'(pc_O), 64'h0);
        check("rst_valid", 64'(pc_valid_O), 64'd0);
        check("rst_epoch", 64'(pc_epoch_O), 64'd0);
        check("rst_halted", 64'(halted_O), 64'd0);
        check("rst_err", 64'(err_O), 64'd0);
        check("rst_cnt", 64'(issued_cnt_O), 64'd0);

        // Boot: valid rises on the second edge after release.
        rst = 1'b0; pc_ready_I = 1'b1;
        push(2'd0, 32'h0); push(2'd0, 32'h4); push(2'd0, 32'h8);
        cycle();
        check("boot_valid0", 64'(pc_valid_O), 64'd0);
        cycle();
        check("boot_valid1", 64'(pc_valid_O), 64'd1);
        check("boot_pc", 64'(pc_O), 64'h0);
        cycle(); cycle();
        check("seq_pc8", 64'(pc_O), 64'h8);
        check("seq_cnt2", 64'(issued_cnt_O), 64'd2);

        // Backpressure holds the offer.
        pc_ready_I = 1'b0;
        cycle(); cycle(); cycle();
        check("stall_pc", 64'(pc_O), 64'h8);
        check("stall_valid", 64'(pc_valid_O), 64'd1);
        check("stall_cnt", 64'(issued_cnt_O), 64'd2);

        // Redirect coincident with accept of 0x8.
        pc_ready_I = 1'b1;
        redirect(32'h100);
        check("redir_pc", 64'(pc_O), 64'h100);
        check("redir_epoch", 64'(pc_epoch_O), 64'd1);
        check("redir_cnt", 64'(issued_cnt_O), 64'd3);

        // Redirects on a stalled offer: epoch wraps 3 -> 0.
        pc_ready_I = 1'b0;
        redirect(32'h200); redirect(32'h300); redirect(32'h400);
        check("wrap_epoch", 64'(pc_epoch_O), 64'd0);
        check("wrap_pc", 64'(pc_O), 64'h400);

        // Halt waits for the outstanding offer to be accepted.
        halt_I = 1'b1;
        cycle();
        check("halt_wait_valid", 64'(pc_valid_O), 64'd1);
        check("halt_wait_halted", 64'(halted_O), 64'd0);
        push(2'd0, 32'h400);
        pc_ready_I = 1'b1;
        cycle();
        check("halt_halted", 64'(halted_O), 64'd1);
        check("halt_valid", 64'(pc_valid_O), 64'd0);
        check("halt_pc", 64'(pc_O), 64'h404);
        check("halt_cnt", 64'(issued_cnt_O), 64'd4);
        redirect(32'h200);
        check("halt_redir_pc", 64'(pc_O), 64'h200);
        check("halt_redir_epoch", 64'(pc_epoch_O), 64'd1);
        check("halt_redir_halted", 64'(halted_O), 64'd1);
        halt_I = 1'b0;
        cycle();
        check("resume_valid", 64'(pc_valid_O), 64'd1);
        check("resume_halted", 64'(halted_O), 64'd0);
        push(2'd1, 32'h200);
        cycle();
        check("resume_pc", 64'(pc_O), 64'h204);

        // Misaligned redirect traps; later redirects are ignored.
        pc_ready_I = 1'b0;
        redirect(32'h102);
        check("err_err", 64'(err_O), 64'd1);
        check("err_valid", 64'(pc_valid_O), 64'd0);
        check("err_pc", 64'(pc_O), 64'h204);
        check("err_epoch", 64'(pc_epoch_O), 64'd1);
        redirect(32'h300);
        check("err_ignore_pc", 64'(pc_O), 64'h204);
        check("err_ignore_epoch", 64'(pc_epoch_O), 64'd1);
        check("err_cnt", 64'(issued_cnt_O), 64'd5);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("arst_err", 64'(err_O), 64'd0);
        check("arst_pc", 64'(pc_O), 64'h0);
        check("arst_cnt", 64'(issued_cnt_O), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(); cycle();

        // Address wrap at the top of the space.
        redirect(32'hFFFF_FFFC);
        check("top_pc", 64'(pc_O), 64'hFFFF_FFFC);
        push(2'd1, 32'hFFFF_FFFC);
        pc_ready_I = 1'b1;
        cycle();
        check("top_wrap_pc", 64'(pc_O), 64'h0);
        check("top_wrap_cnt", 64'(issued_cnt_O), 64'd1);

        // Misaligned redirect together with an accept: counts and advances.
        push(2'd1, 32'h0);
        redirect(32'h6);
        check("err_acc_err", 64'(err_O), 64'd1);
        check("err_acc_pc", 64'(pc_O), 64'h4);
        check("err_acc_cnt", 64'(issued_cnt_O), 64'd2);
        check("err_acc_epoch", 64'(pc_epoch_O), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
